// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register: control-field
// widths, the stage occupancy state type and the default payload width.
package pipe_pkg;

    localparam int unsigned DATA_WIDTH = 128;

    localparam int unsigned EX_W   = 6;
    localparam int unsigned M_W    = 3;
    localparam int unsigned WB_W   = 2;
    localparam int unsigned CTRL_W = EX_W + M_W + WB_W;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [EX_W-1:0] ex;
        logic [M_W-1:0]  m;
        logic [WB_W-1:0] wb;
    } ctrl_bundle_t;

    function automatic logic [1:0] state_occupancy(input stage_state_e s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, stall,
// flush and an optional two-entry skid buffer that registers in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_WIDTH,
    parameter int unsigned CTRL_W = pipe_pkg::CTRL_W,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic              in_fire;
    logic              out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_data  = main_data_q;
    // main_ctrl_q may be stale after a pop, so the bubble is forced here.
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign occupancy = state_occupancy(state_q);

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] skid_data_q, skid_data_d;
            logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

            // Registered ready: depends on the state flops only.
            assign in_ready = (state_q != TWO);

            always_comb begin
                state_d     = state_q;
                main_data_d = main_data_q;
                main_ctrl_d = main_ctrl_q;
                skid_data_d = skid_data_q;
                skid_ctrl_d = skid_ctrl_q;
                case (state_q)
                    EMPTY: begin
                        if (in_fire) begin
                            state_d     = ONE;
                            main_data_d = in_data;
                            main_ctrl_d = in_ctrl;
                        end
                    end
                    ONE: begin
                        if (in_fire && out_fire) begin
                            main_data_d = in_data;
                            main_ctrl_d = in_ctrl;
                        end else if (in_fire) begin
                            state_d     = TWO;
                            skid_data_d = in_data;
                            skid_ctrl_d = in_ctrl;
                        end else if (out_fire) begin
                            state_d = EMPTY;
                        end
                    end
                    TWO: begin
                        if (out_fire) begin
                            state_d     = ONE;
                            main_data_d = skid_data_q;
                            main_ctrl_d = skid_ctrl_q;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
                if (flush) begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    skid_data_q <= '0;
                    skid_ctrl_q <= '0;
                end else begin
                    skid_data_q <= skid_data_d;
                    skid_ctrl_q <= skid_ctrl_d;
                end
            end
        end else begin : g_noskid
            // A full stage can still accept when its head leaves this cycle.
            assign in_ready = !out_valid | out_ready;

            always_comb begin
                state_d     = state_q;
                main_data_d = main_data_q;
                main_ctrl_d = main_ctrl_q;
                case (state_q)
                    EMPTY, ONE: begin
                        if (in_fire) begin
                            state_d     = ONE;
                            main_data_d = in_data;
                            main_ctrl_d = in_ctrl;
                        end else if (out_fire) begin
                            state_d = EMPTY;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
                if (flush) begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
        end
    end

    a_no_fire_in_two: assert property (@(posedge clk) disable iff (rst)
        !(state_q == TWO && in_fire));

    a_ctrl_bubble: assert property (@(posedge clk)
        !out_valid |-> (out_ctrl == '0));

    a_occ_noskid: assert property (@(posedge clk)
        (SKID != 0) || (occupancy <= 2'd1));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a vector table drives the skid variant,
// a small reference model checks the single-register variant.
module tb_pipe_stage_reg;

    localparam int DW = 128;
    localparam int CW = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [1:0]    a_occ;

    logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [1:0]    b_occ;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_ctrl(a_in_ctrl),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .occupancy(a_occ)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_noskid (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_ctrl(b_in_ctrl),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .occupancy(b_occ)
    );

    typedef struct {
        logic          flush;
        logic          in_valid;
        logic [DW-1:0] in_data;
        logic [CW-1:0] in_ctrl;
        logic          out_ready;
        logic          e_valid;
        logic          chk_data;
        logic [DW-1:0] e_data;
        logic [CW-1:0] e_ctrl;
        logic [1:0]    e_occ;
        logic          e_ready;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic fl, input logic iv, input logic [DW-1:0] id,
                                input logic [CW-1:0] ic, input logic ordy,
                                input logic ev, input logic [DW-1:0] ed,
                                input logic [CW-1:0] ec, input logic [1:0] eo,
                                input logic er);
        vec_t v;
        v.flush = fl; v.in_valid = iv; v.in_data = id; v.in_ctrl = ic;
        v.out_ready = ordy; v.e_valid = ev; v.chk_data = ev;
        v.e_data = ed; v.e_ctrl = ev ? ec : '0; v.e_occ = eo; v.e_ready = er;
        return v;
    endfunction

    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [DW-1:0] nxt, exp_pop;
    logic          exp_ir;

    initial begin
        rst = 1'b1;
        a_flush = 0; a_in_valid = 1; a_in_data = 'hA5; a_in_ctrl = '1; a_out_ready = 0;
        b_flush = 0; b_in_valid = 1; b_in_data = 'hA5; b_in_ctrl = '1; b_out_ready = 0;

        // Streaming 1..8 with 1-cycle latency, then drain
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 1, DW'(k), CW'(k), 1, 1, DW'(k), CW'(k), 2'd1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 1));
        // Stall fill into the skid entry, then drain in order
        vecs.push_back(mk(0, 1, 'h10, 'h10, 0, 1, 'h10, 'h10, 2'd1, 1));
        vecs.push_back(mk(0, 1, 'h11, 'h11, 0, 1, 'h10, 'h10, 2'd2, 0));
        vecs.push_back(mk(0, 1, 'h12, 'h12, 0, 1, 'h10, 'h10, 2'd2, 0));
        vecs.push_back(mk(0, 1, 'h12, 'h12, 1, 1, 'h11, 'h11, 2'd1, 1));
        vecs.push_back(mk(0, 1, 'h12, 'h12, 1, 1, 'h12, 'h12, 2'd1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 1));
        // Flush from TWO with a competing in_fire
        vecs.push_back(mk(0, 1, 'h20, 'h7FF, 0, 1, 'h20, 'h7FF, 2'd1, 1));
        vecs.push_back(mk(0, 1, 'h21, 'h7FF, 0, 1, 'h20, 'h7FF, 2'd2, 0));
        vecs.push_back(mk(1, 1, 'h99, 'h055, 0, 0, 0, 0, 2'd0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 1));
        // Simultaneous push and pop in ONE
        vecs.push_back(mk(0, 1, 'h30, 'h001, 0, 1, 'h30, 'h001, 2'd1, 1));
        vecs.push_back(mk(0, 1, 'h31, 'h002, 1, 1, 'h31, 'h002, 2'd1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 2'd0, 1));
        // Flush from ONE discards a same-cycle push
        vecs.push_back(mk(0, 1, 'h40, 'h003, 0, 1, 'h40, 'h003, 2'd1, 1));
        vecs.push_back(mk(1, 1, 'h41, 'h004, 1, 0, 0, 0, 2'd0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1));

        // Reset held for two edges with traffic offered
        repeat (2) @(posedge clk);
        #1;
        chk("rst a out_valid", DW'(a_out_valid), 0);
        chk("rst a out_ctrl",  DW'(a_out_ctrl), 0);
        chk("rst a occupancy", DW'(a_occ), 0);
        chk("rst a out_data",  a_out_data, 0);
        chk("rst b out_valid", DW'(b_out_valid), 0);
        chk("rst b out_ctrl",  DW'(b_out_ctrl), 0);
        chk("rst b occupancy", DW'(b_occ), 0);
        rst = 1'b0;
        a_in_valid = 0; b_in_valid = 0;
        #1;
        chk("rel a in_ready", DW'(a_in_ready), 1);
        chk("rel b in_ready", DW'(b_in_ready), 1);

        for (int i = 0; i < vecs.size(); i++) begin
            a_flush = vecs[i].flush; a_in_valid = vecs[i].in_valid;
            a_in_data = vecs[i].in_data; a_in_ctrl = vecs[i].in_ctrl;
            a_out_ready = vecs[i].out_ready;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), DW'(a_out_valid), DW'(vecs[i].e_valid));
            chk($sformatf("v%0d out_ctrl", i),  DW'(a_out_ctrl), DW'(vecs[i].e_ctrl));
            chk($sformatf("v%0d occupancy", i), DW'(a_occ), DW'(vecs[i].e_occ));
            chk($sformatf("v%0d in_ready", i),  DW'(a_in_ready), DW'(vecs[i].e_ready));
            if (vecs[i].chk_data)
                chk($sformatf("v%0d out_data", i), a_out_data, vecs[i].e_data);
        end
        a_in_valid = 0; a_flush = 0;

        // Single-register variant against a reference model, out_ready toggling
        m_valid = 0; m_data = 0; nxt = 1; exp_pop = 1;
        for (int i = 0; i < 10; i++) begin
            b_out_ready = (i % 2 == 0);
            b_in_valid = 1; b_in_data = nxt; b_in_ctrl = nxt[CW-1:0];
            #1;
            exp_ir = !m_valid | b_out_ready;
            chk($sformatf("b%0d in_ready", i), DW'(b_in_ready), DW'(exp_ir));
            if (m_valid && b_out_ready) begin
                chk($sformatf("b%0d pop order", i), b_out_data, exp_pop);
                exp_pop++;
            end
            if (exp_ir) begin
                m_valid = 1; m_data = nxt; nxt++;
            end
            @(posedge clk);
            #1;
            chk($sformatf("b%0d out_valid", i), DW'(b_out_valid), DW'(m_valid));
            chk($sformatf("b%0d out_data", i), b_out_data, m_data);
            chk($sformatf("b%0d occ<=1", i), DW'(b_occ <= 2'd1), 1);
            chk($sformatf("b%0d occupancy", i), DW'(b_occ), DW'(m_valid));
        end
        b_in_valid = 0; b_out_ready = 1;
        @(posedge clk);
        #1;
        chk("b drain out_valid", DW'(b_out_valid), 0);
        chk("b drain out_ctrl", DW'(b_out_ctrl), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline stage register. Successor to the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a data payload and a separate control bundle (EX/M/WB fields) with a valid/ready handshake.
- Supports hazard-unit stall (backpressure) and flush (bubble insertion).
- Optional two-entry skid buffer gives full throughput with a registered in_ready, which breaks the ready timing path between stages.

Parameters:
- DATA_W, 128, payload width in bits (e.g. pc, data1, data2, imme, rd, rt packed by the instantiating stage).
- CTRL_W, 11, control bundle width (EX 6 + M 3 + WB 2); zeroed on bubble.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational ready.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous squash of all held entries (branch taken / exception).
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept this cycle.
- in_data  input  DATA_W  upstream payload.
- in_ctrl  input  CTRL_W  upstream control bundle.
- out_valid  output  1  downstream entry valid.
- out_ready  input  1  downstream accepts (deasserted = stall).
- out_data  output  DATA_W  head payload.
- out_ctrl  output  CTRL_W  head control; forced all-zero when out_valid=0.
- occupancy  output  2  number of held entries (0..2; max 1 when SKID=0).

Behaviour:
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- States (SKID=1):
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE:
    - in_fire & out_fire -> ONE, main<=in.
    - in_fire & !out_fire -> TWO, skid<=in.
    - !in_fire & out_fire -> EMPTY.
    - otherwise hold.
  - TWO:
    - out_fire -> ONE, main<=skid.
    - otherwise hold. No in_fire is possible in TWO.
- SKID=1 outputs:
  - in_ready = (state != TWO). Decoded from state flops only; no combinational path from out_ready or in_valid.
  - out_valid = (state != EMPTY).
  - out_data/out_ctrl always come from main.
- SKID=0:
  - States EMPTY/ONE only.
  - in_ready = !out_valid | out_ready (combinational).
  - in_fire loads main the same cycle out_fire pops it. Throughput is 1/cycle.
- Latency: an entry accepted at edge N is visible at out_* after edge N (1 cycle), when the stage was EMPTY or ONE-and-draining.
- Ordering: strict FIFO. Skid content never overtakes main.
- Data is never dropped or duplicated except by flush or rst.
- Flush:
  - State -> EMPTY at the next edge. main_ctrl and skid_ctrl are cleared to 0. Data registers may hold stale values.
  - An in_fire in the same cycle as flush is discarded.
  - out_fire in a flush cycle still counts as a completed transfer to downstream; downstream owns its own flush.
- rst dominates flush and all handshakes:
  - State EMPTY, all data/ctrl registers 0, occupancy 0, out_valid 0, out_ctrl 0.
  - in_ready = 1 (SKID=1, decoded from EMPTY; SKID=0, combinational).
  - Reset mid-transfer loses held entries silently.
- Values while held:
  - out_data/out_ctrl are stable while out_valid=1 & out_ready=0.
  - in_data is sampled only on in_fire.
- occupancy: 0/1/2 for EMPTY/ONE/TWO. It is updated in the same edge as state.
- Assertions:
  - !(state==TWO & in_fire).
  - out_ctrl==0 when !out_valid.
  - occupancy <= 1 when SKID=0.

Decomposition:
- Shared package pipe_pkg:
  - stage_state_e enum {EMPTY, ONE, TWO}.
  - Control field widths EX_W=6, M_W=3, WB_W=2, and CTRL_W = EX_W+M_W+WB_W.
  - Use the existing global DATA_WIDTH for payload sizing by instantiators.
- Single module. No sub-module needed; SKID is a generate branch inside it.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1, in_data=0xA5 -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=1 after release.
- Streaming: SKID=1, out_ready=1, in_valid=1 for 8 cycles, data 1..8 -> out_data 1..8 on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Stall fill: SKID=1, push 0x10,0x11,0x12 with out_ready=0 -> occupancy 1 then 2, in_ready=0 after 2nd accept, 0x12 held upstream. Raise out_ready -> outputs 0x10,0x11,0x12 in order, no gaps.
- Flush: occupancy=2 holding ctrl 0x7FF, assert flush with in_valid=1 (0x99) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, 0x99 never emitted.
- SKID=0: out_ready toggling 1,0,1,0 with continuous in_valid -> in_ready tracks !out_valid|out_ready exactly, occupancy never exceeds 1, order preserved.
- Simultaneous: state ONE, in_fire and out_fire same cycle (SKID=1) -> stays ONE, out_data = new value next cycle, occupancy remains 1.
